// File: rtl/afp3_eng_rtry_sched_if.sv
// Bus bundle for the retry scheduler: push path, MMIO controls, decode feedback and
// the presented-entry outputs. The scheduler uses the slave view, its environment the master view.
interface afp3_eng_rtry_sched_if #(
  parameter int BOW = 16
);
  logic [BOW-1:0] mmio_eng_backoff_cnt;
  logic           mmio_eng_clr_err;
  logic           rtry_push_valid;
  logic           rtry_push_cpy_xx;
  logic           rtry_push_cpy_st;
  logic [4:0]     rtry_push_afutag;
  logic [1:0]     rtry_push_type;
  logic           rtry_decode_is_backoff;
  logic           rtry_decode_is_abort;
  logic           rtry_start_any;
  logic           rtry_queue_func_rden_dly2_q;
  logic           rtry_queue_cpy_xx_q;
  logic           rtry_queue_cpy_st_q;
  logic [4:0]     rtry_queue_afutag_q;
  logic           rtry_queue_is_pending_q;
  logic           rtry_queue_is_rtry_lwt_q;
  logic           rtry_queue_is_rtry_req_q;
  logic           rtry_queue_is_rtry_hwt_q;
  logic           rtry_queue_empty;
  logic           rtry_queue_full;
  logic           rtry_backoff_active;
  logic           rtry_overflow_err;
  logic           rtry_orphan_err;
  logic [31:0]    rtry_dispatch_cnt;

  modport slave (
    input  mmio_eng_backoff_cnt, mmio_eng_clr_err,
    input  rtry_push_valid, rtry_push_cpy_xx, rtry_push_cpy_st, rtry_push_afutag, rtry_push_type,
    input  rtry_decode_is_backoff, rtry_decode_is_abort, rtry_start_any,
    output rtry_queue_func_rden_dly2_q, rtry_queue_cpy_xx_q, rtry_queue_cpy_st_q, rtry_queue_afutag_q,
    output rtry_queue_is_pending_q, rtry_queue_is_rtry_lwt_q, rtry_queue_is_rtry_req_q,
    output rtry_queue_is_rtry_hwt_q, rtry_queue_empty, rtry_queue_full, rtry_backoff_active,
    output rtry_overflow_err, rtry_orphan_err, rtry_dispatch_cnt
  );

  modport master (
    output mmio_eng_backoff_cnt, mmio_eng_clr_err,
    output rtry_push_valid, rtry_push_cpy_xx, rtry_push_cpy_st, rtry_push_afutag, rtry_push_type,
    output rtry_decode_is_backoff, rtry_decode_is_abort, rtry_start_any,
    input  rtry_queue_func_rden_dly2_q, rtry_queue_cpy_xx_q, rtry_queue_cpy_st_q, rtry_queue_afutag_q,
    input  rtry_queue_is_pending_q, rtry_queue_is_rtry_lwt_q, rtry_queue_is_rtry_req_q,
    input  rtry_queue_is_rtry_hwt_q, rtry_queue_empty, rtry_queue_full, rtry_backoff_active,
    input  rtry_overflow_err, rtry_orphan_err, rtry_dispatch_cnt
  );
endinterface

// File: rtl/afp3_eng_rtry_sched.sv
// Retry queue with a 2-cycle registered presentation pipeline and backoff pacing.
// Optional macro AFP3_RTRY_SCHED_PERF_CNT_EN builds the 32-bit dispatch counter.
module afp3_eng_rtry_sched #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int BOW   = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  afp3_eng_rtry_sched_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    DLY     = 3'd2,
    PRES    = 3'd3,
    BACKOFF = 3'd4
  } state_t;

  localparam logic [AW:0]    PTR_ONE = (AW+1)'(1);
  localparam logic [BOW-1:0] BO_ONE  = BOW'(1);

  state_t         state, state_nxt;
  logic [AW:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [8:0]     mem [DEPTH];
  logic [8:0]     ent_p1;
  logic           empty, full, empty_nxt, full_nxt;
  logic           push_ok, pop, bo_load;
  logic [BOW-1:0] bo_cnt;
  logic           overflow_err, orphan_err, overflow_set, orphan_set;
  logic           dly2_q, cpy_xx_q, cpy_st_q;
  logic [4:0]     afutag_q;
  logic [3:0]     type_oh_q;

  function automatic logic ptr_empty(input logic [AW:0] w, input logic [AW:0] r);
    return w == r;
  endfunction

  function automatic logic ptr_full(input logic [AW:0] w, input logic [AW:0] r);
    return (w[AW] != r[AW]) && (w[AW-1:0] == r[AW-1:0]);
  endfunction

  // bit 0 lwt, bit 1 req, bit 2 hwt, bit 3 pending
  function automatic logic [3:0] type_onehot(input logic [1:0] t);
    return 4'b0001 << t;
  endfunction

  assign push_ok      = bus.rtry_push_valid & ~full;
  assign pop          = (state == PRES);
  assign wr_ptr_nxt   = push_ok ? wr_ptr + PTR_ONE : wr_ptr;
  assign rd_ptr_nxt   = pop ? rd_ptr + PTR_ONE : rd_ptr;
  assign empty_nxt    = ptr_empty(wr_ptr_nxt, rd_ptr_nxt);
  assign full_nxt     = ptr_full(wr_ptr_nxt, rd_ptr_nxt);
  assign overflow_set = bus.rtry_push_valid & full;
  assign orphan_set   = pop & ~bus.rtry_start_any & ~bus.rtry_decode_is_abort;

  // IDLE and the end of PRES/BACKOFF look at next-cycle occupancy so IDLE is never
  // dwelt in while entries are waiting.
  always_comb begin
    state_nxt = state;
    bo_load   = 1'b0;
    unique case (state)
      IDLE:    if (!empty_nxt) state_nxt = RD;
      RD:      state_nxt = DLY;
      DLY:     state_nxt = PRES;
      PRES: begin
        if (bus.rtry_decode_is_backoff && !bus.rtry_decode_is_abort &&
            (bus.mmio_eng_backoff_cnt != '0)) begin
          bo_load   = 1'b1;
          state_nxt = BACKOFF;
        end else begin
          state_nxt = empty_nxt ? IDLE : RD;
        end
      end
      BACKOFF: if (bo_cnt == BO_ONE) state_nxt = empty_nxt ? IDLE : RD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      bo_cnt       <= '0;
      overflow_err <= 1'b0;
      orphan_err   <= 1'b0;
    end else begin
      state        <= state_nxt;
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      empty        <= empty_nxt;
      full         <= full_nxt;
      overflow_err <= overflow_set | (overflow_err & ~bus.mmio_eng_clr_err);
      orphan_err   <= orphan_set | (orphan_err & ~bus.mmio_eng_clr_err);
      if (bo_load)
        bo_cnt <= bus.mmio_eng_backoff_cnt;
      else if (state == BACKOFF)
        bo_cnt <= bo_cnt - BO_ONE;
    end
  end

  // Storage and stage 1: head entry captured in RD
  always_ff @(posedge clock) begin
    if (push_ok)
      mem[wr_ptr[AW-1:0]] <= {bus.rtry_push_cpy_xx, bus.rtry_push_cpy_st,
                              bus.rtry_push_afutag, bus.rtry_push_type};
    if (state == RD)
      ent_p1 <= mem[rd_ptr[AW-1:0]];
  end

  // Stage 2: presented registers loaded in DLY, qualified by dly2 during PRES
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dly2_q    <= 1'b0;
      cpy_xx_q  <= 1'b0;
      cpy_st_q  <= 1'b0;
      afutag_q  <= '0;
      type_oh_q <= '0;
    end else begin
      dly2_q <= (state == DLY);
      if (state == DLY) begin
        cpy_xx_q  <= ent_p1[8];
        cpy_st_q  <= ent_p1[7];
        afutag_q  <= ent_p1[6:2];
        type_oh_q <= type_onehot(ent_p1[1:0]);
      end
    end
  end

`ifdef AFP3_RTRY_SCHED_PERF_CNT_EN
  logic [31:0] dispatch_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      dispatch_cnt <= '0;
    else if (pop)
      dispatch_cnt <= dispatch_cnt + 32'd1;
  end

  assign bus.rtry_dispatch_cnt = dispatch_cnt;
`else
  assign bus.rtry_dispatch_cnt = '0;
`endif

  assign bus.rtry_queue_func_rden_dly2_q = dly2_q;
  assign bus.rtry_queue_cpy_xx_q         = cpy_xx_q;
  assign bus.rtry_queue_cpy_st_q         = cpy_st_q;
  assign bus.rtry_queue_afutag_q         = afutag_q;
  assign bus.rtry_queue_is_rtry_lwt_q    = type_oh_q[0];
  assign bus.rtry_queue_is_rtry_req_q    = type_oh_q[1];
  assign bus.rtry_queue_is_rtry_hwt_q    = type_oh_q[2];
  assign bus.rtry_queue_is_pending_q     = type_oh_q[3];
  assign bus.rtry_queue_empty            = empty;
  assign bus.rtry_queue_full             = full;
  assign bus.rtry_backoff_active         = (state == BACKOFF);
  assign bus.rtry_overflow_err           = overflow_err;
  assign bus.rtry_orphan_err             = orphan_err;

endmodule
